// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1-style framing, 5..9 data bits) feeding a show-ahead receive FIFO with sticky error flags.
// Optional parity checking is built only when UART_RX_FIFO_PARITY_EN is defined.
module uart_rx_fifo #(
  parameter int clk_freq  = 12000000,
  parameter int baud      = 115200,
  parameter int data_bits = 8,
  parameter int parity    = 0,
  parameter int depth     = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       rx,
  input  logic                       get,
  output logic [data_bits-1:0]       data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(depth):0]     count,
  output logic                       overflow,
  output logic                       frame_err,
  output logic                       parity_err,
  input  logic                       clr_err
);

  localparam int DIV   = (clk_freq + baud / 2) / baud;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam int AW    = $clog2(depth);
  localparam int BIT_W = $clog2(data_bits + 1);

  if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: depth must be a power of two >= 2");
  end
  if (data_bits < 5 || data_bits > 9) begin : g_bad_bits
    $error("uart_rx_fifo: data_bits must be 5..9");
  end
  if (parity < 0 || parity > 2) begin : g_bad_parity
    $error("uart_rx_fifo: parity must be 0, 1 or 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_fifo: clk_freq/baud must be at least 2");
  end

`ifdef UART_RX_FIFO_PARITY_EN
  typedef enum logic [2:0] {S_ARM, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_ARM, S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [1:0]           arm_cnt;
  logic                 rx_s1, rx_s2;
  logic [data_bits-1:0] shreg;
  logic                 par_bad;

  logic [AW:0]          wptr, rptr;
  logic [data_bits-1:0] mem [depth];

  logic tick, data_smp, stop_smp, pop, push;
  logic frm_evt, par_evt, ovf_evt;

  // Input synchronizer; idle level is high
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  always_comb begin
    tick     = (cnt == '0);
    data_smp = (state == S_DATA) && tick;
    stop_smp = (state == S_STOP) && tick;
    pop      = get && !empty;
    frm_evt  = stop_smp && !rx_s2;
    par_evt  = stop_smp && rx_s2 && par_bad;
    ovf_evt  = stop_smp && rx_s2 && !par_bad && full && !pop;
    push     = stop_smp && rx_s2 && !par_bad && (!full || pop);
  end

  // Receiver FSM; ARM also lets the synchronizer flush after reset before trusting rx
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_ARM;
      cnt     <= '0;
      bit_idx <= '0;
      arm_cnt <= '0;
    end else begin
      case (state)
        S_ARM: begin
          if (arm_cnt != 2'd2) arm_cnt <= arm_cnt + 2'd1;
          else if (rx_s2)      state   <= S_IDLE;
        end
        S_IDLE: begin
          if (!rx_s2) begin
            state <= S_START;
            cnt   <= CNT_W'(HALF - 1);
          end
        end
        S_START: begin
          if (tick) begin
            if (!rx_s2) begin
              state   <= S_DATA;
              cnt     <= CNT_W'(DIV - 1);
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt <= CNT_W'(DIV - 1);
            if (bit_idx == BIT_W'(data_bits - 1)) begin
`ifdef UART_RX_FIFO_PARITY_EN
              state <= (parity != 0) ? S_PARITY : S_STOP;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef UART_RX_FIFO_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            cnt   <= CNT_W'(DIV - 1);
            state <= S_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tick) state <= rx_s2 ? S_IDLE : S_ARM;
          else      cnt   <= cnt - 1'b1;
        end
        default: state <= S_ARM;
      endcase
    end
  end

  // LSB arrives first, so shift in from the top
  always_ff @(posedge clk) begin
    if (data_smp) shreg <= {rx_s2, shreg[data_bits-1:1]};
  end

`ifdef UART_RX_FIFO_PARITY_EN
  // Verdict is held until the stop bit decides whether the frame is pushed
  always_ff @(posedge clk) begin
    if (!resetn) begin
      par_bad <= 1'b0;
    end else if (state == S_START) begin
      par_bad <= 1'b0;
    end else if (state == S_PARITY && tick) begin
      if (parity == 1)      par_bad <= ~(^shreg ^ rx_s2);
      else if (parity == 2) par_bad <= ^shreg ^ rx_s2;
      else                  par_bad <= 1'b0;
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  // FIFO storage: not reset, written only on an accepted push
  always_ff @(posedge clk) begin
    if (resetn && push) mem[wptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign data  = mem[rptr[AW-1:0]];

  // A new event wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | ovf_evt;
      frame_err <= (frame_err & ~clr_err) | frm_evt;
    end
  end

`ifdef UART_RX_FIFO_PARITY_EN
  always_ff @(posedge clk) begin
    if (!resetn) parity_err <= 1'b0;
    else         parity_err <= (parity_err & ~clr_err) | par_evt;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DIV=10, depth=4, 8 data bits (even parity when UART_RX_FIFO_PARITY_EN is defined).
module tb_uart_rx_fifo;
  localparam int DIV   = 10;
  localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_PARITY_EN
  localparam int PAR    = 2;
  localparam int PAR_ON = 1;
`else
  localparam int PAR    = 0;
  localparam int PAR_ON = 0;
`endif
  // Edge (counted from the start-bit edge) on which the stop bit is sampled
  localparam int STOP_EDGE = 8 + DIV * (8 + PAR_ON + 1);

  logic       clk, resetn, rx, get, clr_err;
  logic [7:0] data;
  logic       empty, full, overflow, frame_err, parity_err;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(
    .clk_freq(1000000), .baud(100000), .data_bits(8), .parity(PAR), .depth(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn), .rx(rx), .get(get), .data(data), .empty(empty),
    .full(full), .count(count), .overflow(overflow), .frame_err(frame_err),
    .parity_err(parity_err), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {OP_SEND, OP_POP, OP_CLR, OP_GLITCH} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] d;
    bit         stop;
    int         e_count;
    bit         e_empty;
    bit         e_full;
    bit         chk_data;
    logic [7:0] e_data;
    bit         e_ovf;
    bit         e_fe;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit bad_par);
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge clk); #1 rx = d[i];
    end
    if (PAR_ON != 0) begin
      repeat (DIV) @(posedge clk); #1 rx = (^d) ^ bad_par;
    end
    repeat (DIV) @(posedge clk); #1 rx = stop;
    repeat (DIV) @(posedge clk); #1 rx = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  task automatic pulse_get();
    @(posedge clk); #1 get = 1'b1;
    @(posedge clk); #1 get = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
  endtask

  task automatic glitch();
    @(posedge clk); #1 rx = 1'b0;
    repeat (3) @(posedge clk); #1 rx = 1'b1;
    repeat (30) @(posedge clk);
  endtask

  task automatic check_status(input string tag, input int e_count, input bit e_empty, input bit e_full,
                              input bit e_ovf, input bit e_fe);
    check({tag, " count"}, int'(count), e_count);
    check({tag, " empty"}, int'(empty), int'(e_empty));
    check({tag, " full"}, int'(full), int'(e_full));
    check({tag, " overflow"}, int'(overflow), int'(e_ovf));
    check({tag, " frame_err"}, int'(frame_err), int'(e_fe));
  endtask

  initial begin
    vecs[0]  = '{OP_SEND,   8'h55, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1]  = '{OP_SEND,   8'hA3, 1'b1, 2, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[2]  = '{OP_POP,    8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0};
    vecs[3]  = '{OP_POP,    8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{OP_SEND,   8'h01, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{OP_SEND,   8'h02, 1'b1, 2, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[6]  = '{OP_SEND,   8'h03, 1'b1, 3, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7]  = '{OP_SEND,   8'h04, 1'b1, 4, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[8]  = '{OP_SEND,   8'h05, 1'b1, 4, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[9]  = '{OP_POP,    8'h00, 1'b1, 3, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[10] = '{OP_POP,    8'h00, 1'b1, 2, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[11] = '{OP_POP,    8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0};
    vecs[12] = '{OP_POP,    8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[13] = '{OP_CLR,    8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[14] = '{OP_SEND,   8'h7E, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[15] = '{OP_SEND,   8'h31, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'h31, 1'b0, 1'b1};
    vecs[16] = '{OP_POP,    8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[17] = '{OP_CLR,    8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[18] = '{OP_GLITCH, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    resetn = 1'b0; rx = 1'b1; get = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check_status("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset parity_err", int'(parity_err), 0);

    for (int i = 0; i < 19; i++) begin
      case (vecs[i].op)
        OP_SEND:   send_frame(vecs[i].d, vecs[i].stop, 1'b0);
        OP_POP:    pulse_get();
        OP_CLR:    pulse_clr();
        default:   glitch();
      endcase
      @(negedge clk);
      check_status($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_empty, vecs[i].e_full,
                   vecs[i].e_ovf, vecs[i].e_fe);
      check($sformatf("vec%0d parity_err", i), int'(parity_err), 0);
      if (vecs[i].chk_data) check($sformatf("vec%0d data", i), int'(data), int'(vecs[i].e_data));
    end

    // Pop on the very edge that samples the stop bit of a frame arriving while full
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    @(negedge clk);
    check_status("fill", 4, 1'b0, 1'b1, 1'b0, 1'b0);
    fork
      send_frame(8'h99, 1'b1, 1'b0);
      begin
        @(posedge clk);
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 get = 1'b1;
        @(posedge clk); #1 get = 1'b0;
      end
    join
    @(negedge clk);
    check_status("popfull", 4, 1'b0, 1'b1, 1'b0, 1'b0);
    begin
      logic [7:0] exp_q [4];
      exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'h99;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("popfull data%0d", i), int'(data), int'(exp_q[i]));
        pulse_get();
        @(negedge clk);
      end
    end
    check("popfull drained empty", int'(empty), 1);

`ifdef UART_RX_FIFO_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b1);
    @(negedge clk);
    check("parity bad flag", int'(parity_err), 1);
    check("parity bad count", int'(count), 0);
    send_frame(8'h01, 1'b1, 1'b0);
    @(negedge clk);
    check("parity good count", int'(count), 1);
    check("parity good data", int'(data), 8'h01);
    pulse_get();
    pulse_clr();
    @(negedge clk);
    check("parity cleared", int'(parity_err), 0);
`endif

    // Reset in the middle of a frame, with rx held low across the release
    send_frame(8'h11, 1'b1, 1'b0);
    @(negedge clk);
    check("pre-reset count", int'(count), 1);
    @(posedge clk); #1 rx = 1'b0;
    repeat (30) @(posedge clk);
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check_status("midreset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (150) @(posedge clk);
    @(negedge clk);
    check_status("rxlow", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 rx = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'h5A, 1'b1, 1'b0);
    @(negedge clk);
    check_status("post-reset", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post-reset data", int'(data), 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
